debounce_sched: RTL and testbench
=================================

DEBOUNCE_SCHED -- requirements
Module: debounce_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel, at least 2.
REQ-003 SHALL have parameter TICK_DIV_L2, default 10: sample tick period is 2^TICK_DIV_L2 clocks.
REQ-004 SHALL have parameter STABLE_TICKS, default 8: consecutive differing ticks needed to accept a change, 1..15.
REQ-005 SHALL have port i_clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_din  input  N_CH  raw asynchronous channel inputs.
REQ-008 SHALL have port o_state  output  N_CH  debounced level per channel.
REQ-009 SHALL have port o_evt_valid  output  1  event available.
REQ-010 SHALL have port i_evt_ready  input  1  consumer accepts event.
REQ-011 SHALL have port o_evt_ch  output  $clog2(N_CH)  channel index of the event.
REQ-012 SHALL have port o_evt_rise  output  1  1 for a rising edge, 0 for a falling edge.
REQ-013 SHALL have port o_overflow  output  1  sticky lost-event flag.
REQ-014 SHALL have port i_ovf_clr  input  1  clears o_overflow.

Function
REQ-015 Each channel SHALL pass i_din[c] through SYNC_STAGES flops; the last stage is sync[c].
REQ-016 One shared free-running TICK_DIV_L2-bit prescaler SHALL assert tick for one clock when all ones.
REQ-017 Per channel, if sync[c]==o_state[c], the 4-bit counter SHALL clear that clock regardless of tick.
REQ-018 If sync[c]!=o_state[c] and tick, the counter SHALL increment.
REQ-019 If the counter equals STABLE_TICKS-1 when it would increment, o_state[c] SHALL toggle, the counter SHALL clear, pend[c] SHALL set and rise[c] SHALL take the new level; no counter wrap is possible.
REQ-020 Output event register SHALL load when o_evt_valid==0 or (o_evt_valid and i_evt_ready), if any pend bit is set.
REQ-021 Grant SHALL be round-robin, searching from last granted channel +1 with wrap to 0; after reset the search starts at channel 0.
REQ-022 The loaded channel's pend bit SHALL clear in the load clock; o_evt_valid rises one clock after pend set, minimum.
REQ-023 While o_evt_valid and !i_evt_ready, o_evt_ch and o_evt_rise SHALL hold stable.
REQ-024 A handshake with no pend set SHALL drop o_evt_valid next clock; a handshake with a pend set SHALL give back-to-back events.
REQ-025 Same channel setting pend in its own grant clock SHALL leave pend set with the new rise, and SHALL NOT count as overflow.
REQ-026 Latency SHALL be: input change to o_state toggle = SYNC_STAGES + clocks until STABLE_TICKS ticks + 1.

Reset
REQ-027 Reset SHALL clear sync flops, prescaler, counters, pend, rise, o_state, o_evt_valid, o_evt_ch, o_evt_rise, o_overflow and the RR pointer, all to 0.
REQ-028 Reset mid-event SHALL discard all pending and presented events; no event is emitted for levels already high at release until they debounce.

Configuration
REQ-029 With DEBOUNCE_SCHED_OVF_EN defined, a pend set on an already-pending, ungranted channel SHALL set o_overflow and overwrite rise; o_overflow holds until i_ovf_clr, and a set wins over a simultaneous clear.
REQ-030 Without DEBOUNCE_SCHED_OVF_EN, o_overflow SHALL be constant 0, i_ovf_clr ignored, and rise silently overwritten.

Structure
REQ-031 Package debounce_pkg SHALL hold the evt_t struct (ch, rise), the counter-width constant (4) and the parameter limits.
REQ-032 Per-channel synchronizer plus counter plus o_state SHALL be sub-module debounce_chan, instantiated N_CH times with a shared tick input.

Verification
Bench parameters: N_CH=4, TICK_DIV_L2=2, STABLE_TICKS=3.
REQ-033 Channel 1 steps 0->1 held -> o_state[1]=1 after the third tick; one event ch=1 rise=1; ready high gives valid for 1 clock.
REQ-034 Channel 0 bounces 1-0-1 at 1-tick spacing -> no o_state change and no event; counter clears each match.
REQ-035 Channels 0, 2, 3 debounce in the same clock with ready=1 -> events ch 0,2,3 on consecutive clocks; a later channel-0 event after last grant 3 comes out as ch=0.
REQ-036 Ready=0 while valid, ch=2 rise=1 -> outputs stable 20 clocks; release ready -> accepted once.
REQ-037 OVF_EN with ready=0: channel 1 rises then falls while pending -> o_overflow=1, delivered event ch=1 rise=0; i_ovf_clr -> 0.
REQ-038 Assert reset while valid=1 and pend=0b0110 -> all outputs 0 next clock; no events after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce/event scheduler.
package debounce_pkg;
  localparam int CNT_W      = 4;
  localparam int CH_W_MAX   = 4;
  localparam int N_CH_MIN   = 2;
  localparam int N_CH_MAX   = 16;
  localparam int SYNC_MIN   = 2;
  localparam int STABLE_MIN = 1;
  localparam int STABLE_MAX = 15;

  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic                rise;
  } evt_t;
endpackage

// File: rtl/debounce_sched_if.sv
// Event handshake bundle: the event transfers on a clock where valid && ready;
// once valid is high, ch/rise hold until that transfer.
interface debounce_sched_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic            valid;
  logic            ready;
  logic [CH_W-1:0] ch;
  logic            rise;

  modport master (output valid, ch, rise, input ready);
  modport slave  (input valid, ch, rise, output ready);
endinterface

// File: rtl/debounce_chan.sv
// One channel: input synchronizer, stability counter and debounced level.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 8
) (
  input  logic i_clk,
  input  logic reset,
  input  logic din_i,
  input  logic tick_i,
  output logic state_o,
  output logic fire_o
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   sync;
  logic                   fire;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any clock where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    fire    = 1'b0;
    if (sync == state_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LIMIT) begin
        state_d = ~state_q;
        cnt_d   = '0;
        fire    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign fire_o  = fire;
endmodule

// File: rtl/debounce_sched.sv
// Multi-channel debouncer with a round-robin edge-event queue.
// Optional DEBOUNCE_SCHED_OVF_EN enables the sticky lost-event flag.
module debounce_sched
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV_L2  = 10,
  parameter int STABLE_TICKS = 8
) (
  input  logic                    i_clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         i_din,
  output logic [N_CH-1:0]         o_state,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [$clog2(N_CH)-1:0] o_evt_ch,
  output logic                    o_evt_rise,
  output logic                    o_overflow,
  input  logic                    i_ovf_clr
);
  localparam int CH_W = $clog2(N_CH);

  logic [TICK_DIV_L2-1:0] presc_q;
  logic                   tick;
  logic [N_CH-1:0]        fire;
  logic [N_CH-1:0]        pend_q, pend_d;
  logic [N_CH-1:0]        rise_q, rise_d;
  logic [N_CH-1:0]        gnt_oh;
  logic [CH_W-1:0]        start_q, start_d;
  logic [CH_W-1:0]        gnt_idx;
  logic                   gnt_found;
  logic                   load, grant;
  logic                   valid_q;
  evt_t                   evt_q;
  int                     k;

  assign tick = &presc_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .i_clk  (i_clk),
      .reset  (reset),
      .din_i  (i_din[c]),
      .tick_i (tick),
      .state_o(o_state[c]),
      .fire_o (fire[c])
    );
  end

  // First pending channel at or after start_q, wrapping past N_CH-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    k         = 0;
    for (int i = 0; i < N_CH; i++) begin
      k = (int'(start_q) + i) % N_CH;
      if (!gnt_found && pend_q[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(k);
      end
    end
  end

  assign load  = !valid_q || i_evt_ready;
  assign grant = load && gnt_found;

  // A new fire beats the grant clear, so a re-trigger in the grant clock stays pending.
  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[gnt_idx] = 1'b1;
    pend_d  = (pend_q & ~gnt_oh) | fire;
    rise_d  = rise_q;
    for (int c = 0; c < N_CH; c++) begin
      if (fire[c]) rise_d[c] = ~o_state[c];
    end
    start_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      pend_q  <= '0;
      rise_q  <= '0;
      start_q <= '0;
      valid_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      pend_q  <= pend_d;
      rise_q  <= rise_d;
      if (grant) begin
        valid_q  <= 1'b1;
        evt_q.ch <= CH_W_MAX'(gnt_idx);
        evt_q.rise <= rise_q[gnt_idx];
        start_q  <= start_d;
      end else if (load) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_ch    = evt_q.ch[CH_W-1:0];
  assign o_evt_rise  = evt_q.rise;

  logic unused_evt_ch;
  assign unused_evt_ch = ^evt_q.ch;

`ifdef DEBOUNCE_SCHED_OVF_EN
  logic ovf_q;
  logic ovf_set;

  // Lost event: a channel re-fires while its previous edge is still queued.
  assign ovf_set = |(fire & pend_q & ~gnt_oh);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset)          ovf_q <= 1'b0;
    else if (ovf_set)   ovf_q <= 1'b1;
    else if (i_ovf_clr) ovf_q <= 1'b0;
  end

  assign o_overflow = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = i_ovf_clr;
  assign o_overflow     = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched with a queued scoreboard on the event port.
module tb_debounce_sched;
  localparam int N_CH = 4;
  localparam int W    = 3;
`ifdef DEBOUNCE_SCHED_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] i_din;
  logic [N_CH-1:0] o_state;
  logic            o_overflow;
  logic            i_ovf_clr;

  debounce_sched_if #(.N_CH(N_CH)) evt_if ();

  debounce_sched #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .TICK_DIV_L2 (2),
    .STABLE_TICKS(3)
  ) dut (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_din      (i_din),
    .o_state    (o_state),
    .o_evt_valid(evt_if.valid),
    .i_evt_ready(evt_if.ready),
    .o_evt_ch   (evt_if.ch),
    .o_evt_rise (evt_if.rise),
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  int           hs_cyc[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           vcount   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: one pop per accepted event, sampled mid-cycle.
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    cyc++;
    if (!reset && evt_if.valid) vcount++;
    if (!reset && evt_if.valid && evt_if.ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_evt: got ch=%0d rise=%0d expected none", evt_if.ch, evt_if.rise);
      end else begin
        e = exp_q.pop_front();
        check("evt", {29'd0, evt_if.ch, evt_if.rise}, {29'd0, e});
      end
    end
  end

  task automatic tick_n(int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_state(string name, int c, logic v, int bound);
    logic ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (o_state[c] == v) ok = 1'b1;
      else tick_n(1);
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_valid(string name, int bound);
    logic ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (evt_if.valid) ok = 1'b1;
      else tick_n(1);
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick_n(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    logic bad;
    reset        = 1'b1;
    i_din        = '0;
    i_ovf_clr    = 1'b0;
    evt_if.ready = 1'b0;
    tick_n(3);
    check("rst_state", {28'd0, o_state}, 32'd0);
    check("rst_valid", {31'd0, evt_if.valid}, 32'd0);
    check("rst_ch", {30'd0, evt_if.ch}, 32'd0);
    check("rst_rise", {31'd0, evt_if.rise}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    reset = 1'b0;
    tick_n(2);

    // Single rising edge on channel 1, consumer always ready.
    evt_if.ready = 1'b1;
    vcount = 0;
    i_din[1] = 1'b1;
    exp_q.push_back({2'd1, 1'b1});
    tick_n(5);
    check("t1_no_early", {31'd0, o_state[1]}, 32'd0);
    wait_state("t1_state", 1, 1'b1, 30);
    tick_n(6);
    check("t1_valid_cycles", vcount, 32'd1);
    check("t1_valid_low", {31'd0, evt_if.valid}, 32'd0);
    check("t1_drained", exp_q.size(), 32'd0);

    // Channel 0 bounces at one-tick spacing: never stable for three ticks.
    vcount = 0;
    i_din[0] = 1'b1; tick_n(4);
    i_din[0] = 1'b0; tick_n(4);
    i_din[0] = 1'b1; tick_n(4);
    i_din[0] = 1'b0; tick_n(20);
    check("t2_state", {31'd0, o_state[0]}, 32'd0);
    check("t2_no_evt", vcount, 32'd0);

    // Back-pressure: event must hold while ready is low.
    evt_if.ready = 1'b0;
    i_din[2] = 1'b1;
    exp_q.push_back({2'd2, 1'b1});
    wait_valid("t3_valid", 40);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!(evt_if.valid && evt_if.ch == 2'd2 && evt_if.rise)) bad = 1'b1;
      tick_n(1);
    end
    check("t3_stable", {31'd0, bad}, 32'd0);
    hs0 = hs_cyc.size();
    evt_if.ready = 1'b1;
    tick_n(3);
    check("t3_once", hs_cyc.size() - hs0, 32'd1);
    check("t3_valid_low", {31'd0, evt_if.valid}, 32'd0);

    // Channel 1 re-fires while still queued behind a held channel 3 event.
    i_din = '0;
    do_reset();
    evt_if.ready = 1'b0;
    i_din[3] = 1'b1;
    exp_q.push_back({2'd3, 1'b1});
    wait_valid("t4_valid", 40);
    i_din[1] = 1'b1;
    wait_state("t4_rise", 1, 1'b1, 30);
    i_din[1] = 1'b0;
    wait_state("t4_fall", 1, 1'b0, 30);
    tick_n(2);
    check("t4_ovf_set", {31'd0, o_overflow}, {31'd0, OVF_EXP});
    exp_q.push_back({2'd1, 1'b0});
    hs0 = hs_cyc.size();
    evt_if.ready = 1'b1;
    tick_n(4);
    check("t4_two_evts", hs_cyc.size() - hs0, 32'd2);
    check("t4_drained", exp_q.size(), 32'd0);
    check("t4_ovf_hold", {31'd0, o_overflow}, {31'd0, OVF_EXP});
    i_ovf_clr = 1'b1;
    tick_n(1);
    i_ovf_clr = 1'b0;
    tick_n(1);
    check("t4_ovf_clr", {31'd0, o_overflow}, 32'd0);

    // Three channels debounce together: round-robin, back-to-back.
    i_din = '0;
    do_reset();
    evt_if.ready = 1'b1;
    hs0 = hs_cyc.size();
    i_din = 4'b1101;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    wait_state("t5_state", 3, 1'b1, 40);
    tick_n(6);
    check("t5_count", hs_cyc.size() - hs0, 32'd3);
    if (hs_cyc.size() - hs0 == 3)
      check("t5_back_to_back", hs_cyc[hs0+2] - hs_cyc[hs0], 32'd2);
    i_din = 4'b1000;
    exp_q.push_back({2'd0, 1'b0});
    exp_q.push_back({2'd2, 1'b0});
    wait_state("t5_fall", 0, 1'b0, 40);
    tick_n(6);
    check("t5_drained", exp_q.size(), 32'd0);

    // Reset while an event is presented and channels 1 and 2 are pending.
    evt_if.ready = 1'b0;
    i_din[3] = 1'b0;
    exp_q.push_back({2'd3, 1'b0});
    wait_valid("t6_valid", 40);
    i_din[1] = 1'b1;
    i_din[2] = 1'b1;
    wait_state("t6_pend", 2, 1'b1, 40);
    tick_n(1);
    check("t6_presented", {29'd0, evt_if.valid, evt_if.ch}, {29'd0, 1'b1, 2'd3});
    reset = 1'b1;
    exp_q.delete();
    tick_n(1);
    check("t6_rst_state", {28'd0, o_state}, 32'd0);
    check("t6_rst_evt", {28'd0, evt_if.valid, evt_if.ch, evt_if.rise}, 32'd0);
    check("t6_rst_ovf", {31'd0, o_overflow}, 32'd0);
    evt_if.ready = 1'b1;
    vcount = 0;
    reset = 1'b0;
    tick_n(5);
    check("t6_quiet", vcount, 32'd0);
    exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b1});
    wait_state("t6_redebounce", 2, 1'b1, 40);
    tick_n(6);
    check("t6_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
